// File: rtl/my_top_level_pkg.sv
// Shared definitions for the my_top_level adder slice: default width,
// operand/result type and the all-ones saturation limit.
package my_top_level_pkg;

  // Default operand and result width in bits.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Widest operand the block supports.
  localparam int unsigned MAX_WIDTH = 32;

  // Operand/result type at the default width.
  typedef logic [DEFAULT_WIDTH-1:0] operand_t;

  // All-ones value (2^width - 1) for widths 1..32, returned in 32 bits.
  function automatic logic [MAX_WIDTH-1:0] sat_limit(input int unsigned width);
    logic [MAX_WIDTH-1:0] lim;
    lim = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) lim[i] = 1'b1;
    end
    return lim;
  endfunction

endpackage

// File: rtl/my_top_level_add.sv
// Combinational WIDTH-bit adder with carry-out. The sum is formed at
// WIDTH+1 bits; by default the result wraps modulo 2^WIDTH, and with
// MY_TOP_LEVEL_SAT_EN defined it clamps to all-ones on overflow.
module my_top_level_add
  import my_top_level_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full_sum;

`ifdef MY_TOP_LEVEL_SAT_EN
  logic [MAX_WIDTH-1:0] limit;
`endif

  // Full-precision add, then select wrapped or saturated result.
  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b};
    carry    = full_sum[WIDTH];
`ifdef MY_TOP_LEVEL_SAT_EN
    limit = sat_limit(WIDTH);
    if (full_sum[WIDTH]) begin
      sum = limit[WIDTH-1:0];
    end else begin
      sum = full_sum[WIDTH-1:0];
    end
`else
    sum = full_sum[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/my_top_level.sv
// Registered WIDTH-bit unsigned adder, one cycle latency, synchronous
// active-high reset. Define MY_TOP_LEVEL_SAT_EN for saturating addition;
// the default build wraps modulo 2^WIDTH.
module my_top_level
  import my_top_level_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  output logic [WIDTH-1:0] io_X
);

  logic [WIDTH-1:0] add_sum;
  // Carry is provided by the adder but the output register has no use for it.
  logic             carry_unused;

  my_top_level_add #(
    .WIDTH(WIDTH)
  ) u_add (
    .a    (io_A),
    .b    (io_B),
    .sum  (add_sum),
    .carry(carry_unused)
  );

  // Output register: cleared on reset, otherwise loads this edge's sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_X <= '0;
    end else begin
      io_X <= add_sum;
    end
  end

endmodule

// File: tb/tb_my_top_level.sv
// Scoreboard bench for my_top_level at WIDTH=8 (directed + random) and
// WIDTH=16 (random operands throughout). Define MY_TOP_LEVEL_SAT_EN to
// check the saturating build.
module tb_my_top_level;

`ifdef MY_TOP_LEVEL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, x8;
  logic [15:0] a16 = '0, b16 = '0, x16;

  always #5 clk = ~clk;

  my_top_level #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .reset(reset),
    .io_A (a8),
    .io_B (b8),
    .io_X (x8)
  );

  my_top_level #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .reset(reset),
    .io_A (a16),
    .io_B (b16),
    .io_X (x16)
  );

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } item_t;

  item_t q8[$];
  item_t q16[$];
  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input int unsigned w);
    logic [32:0] s;
    logic [32:0] mask;
    s    = {1'b0, a} + {1'b0, b};
    mask = (33'd1 << w) - 33'd1;
    if (SAT) begin
      if (s > mask) return mask[31:0];
      return s[31:0];
    end
    return s[31:0] & mask[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (away from the rising edge) and queue the
  // expected registered outputs for both DUTs.
  task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input string tag);
    logic [15:0] ra, rb;
    @(negedge clk);
    ra    = 16'($urandom);
    rb    = 16'($urandom);
    reset = r;
    a8    = a;
    b8    = b;
    a16   = ra;
    b16   = rb;
    q8.push_back('{exp: {24'd0, exp}, tag: tag});
    q16.push_back('{exp: (r ? 32'd0 : model({16'd0, ra}, {16'd0, rb}, 16)),
                    tag: {tag, "_w16"}});
    @(posedge clk);
  endtask

  // Monitor: output is valid every cycle, compare just after each edge.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        it = q8.pop_front();
        check(it.tag, {24'd0, x8}, it.exp);
      end
      if (q16.size() > 0) begin
        it = q16.pop_front();
        check(it.tag, {16'd0, x16}, it.exp);
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;

    // Reset held for three cycles with nonzero operands.
    step(1'b1, 8'h12, 8'h34, 8'h00, "rst_c1");
    step(1'b1, 8'h12, 8'h34, 8'h00, "rst_c2");
    step(1'b1, 8'h12, 8'h34, 8'h00, "rst_c3");
    step(1'b0, 8'h12, 8'h34, 8'h46, "rst_release");

    // Latency and hold between edges.
    step(1'b0, 8'h05, 8'h03, 8'h08, "latency");
    #2;
    a8 = 8'hAA;
    b8 = 8'h55;
    #2;
    check("hold_mid_cycle", {24'd0, x8}, 32'h08);

    // Overflow corners.
    step(1'b0, 8'hFF, 8'h01, SAT ? 8'hFF : 8'h00, "ovf_ff_01");
    step(1'b0, 8'h80, 8'h80, SAT ? 8'hFF : 8'h00, "ovf_80_80");
    step(1'b0, 8'hFF, 8'hFF, SAT ? 8'hFF : 8'hFE, "ovf_ff_ff");
    step(1'b0, 8'h7F, 8'h80, 8'hFF, "no_ovf_max");

    // Back-to-back streaming.
    step(1'b0, 8'd1,   8'd2,   8'd3,   "stream0");
    step(1'b0, 8'd10,  8'd20,  8'd30,  "stream1");
    step(1'b0, 8'd100, 8'd100, 8'd200, "stream2");
    step(1'b0, 8'd200, 8'd55,  8'd255, "stream3");

    // Streaming with a one-cycle reset in the middle.
    step(1'b0, 8'd1,   8'd2,   8'd3,   "mrst0");
    step(1'b0, 8'd10,  8'd20,  8'd30,  "mrst1");
    step(1'b1, 8'd100, 8'd100, 8'd0,   "mrst_reset");
    step(1'b0, 8'd200, 8'd55,  8'd255, "mrst_after");

    // Random operands against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      step(1'b0, ra, rb, model({24'd0, ra}, {24'd0, rb}, 8) & 32'hFF, "rand");
    end

    // Let the monitor drain, bounded to a few cycles.
    for (int i = 0; i < 4 && (q8.size() + q16.size()) > 0; i++) @(posedge clk);
    #2;
    check("drain", q8.size() + q16.size(), 32'd0);
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL timeout: got stimulus incomplete expected complete");
      $fatal(1, "timeout");
    end
  end

endmodule
